// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the cartridge SRAM arbiter.
// Sequencer states, owner codes and timing constants.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WS,
        WP,
        WH,
        DONE,
        TURN
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    localparam int DEF_ADDR_W    = 21;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_RD_CYCLES = 2;
    localparam int DEF_WR_CYCLES = 2;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker for the SRAM arbiter.
// Bit 0 is port A, bit 1 is port B; grant is one-hot.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    // 1 = port B has priority on the next contended grant
    logic prio_b;

    // Pick the single requester, or the one not served last
    always_comb begin
        grant = 2'b00;
        if (grant_en) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_b ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Hand priority to the port that did not just win
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_b <= 1'b0;
        end else if (|grant) begin
            prio_b <= grant[0];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the cartridge SRAM between the AVR bus FSM (A) and SNES bus (B).
// Arbitrates in IDLE and sequences ce_n/oe_n/we_n and data direction.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_CYCLES = DEF_RD_CYCLES,
    parameter int WR_CYCLES = DEF_WR_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [1:0]        owner
);

    localparam int CNT_MAX = max2(RD_CYCLES, WR_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant;
    logic [1:0]        own;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              rd_last;

    sram_arb_rr u_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      ({b_req, a_req}),
        .grant_en (state == IDLE),
        .grant    (grant)
    );

    assign rd_last   = (state == RD) && (cnt == RD_LAST);
    assign a_ack     = (state == DONE) && (own == OWN_A);
    assign b_ack     = (state == DONE) && (own == OWN_B);
    assign sram_addr = addr_q;
    assign sram_dq_o = wdata_q;
    assign owner     = own;

    // Sequencer state register; reset aborts any access at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and strobe decode, all strobes idle by default
    always_comb begin
        state_n    = state;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state)
            IDLE: begin
                if (grant[0]) begin
                    state_n = a_we ? WS : RD;
                end else if (grant[1]) begin
                    state_n = b_we ? WS : RD;
                end
            end
            RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                if (cnt == RD_LAST) begin
                    state_n = DONE;
                end
            end
            WS: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                state_n    = WP;
            end
            WP: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_dq_oe = 1'b1;
                if (cnt == WR_LAST) begin
                    state_n = WH;
                end
            end
            WH: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                state_n    = DONE;
            end
            DONE: begin
                state_n = we_q ? TURN : IDLE;
            end
            TURN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Pulse-width counter, restarts on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state_n != state) begin
            cnt <= '0;
        end else if (state == RD || state == WP) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Latch the winner's request at grant; drop ownership after DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            own     <= OWN_NONE;
        end else if (grant[0]) begin
            addr_q  <= a_addr;
            wdata_q <= a_wdata;
            we_q    <= a_we;
            own     <= OWN_A;
        end else if (grant[1]) begin
            addr_q  <= b_addr;
            wdata_q <= b_wdata;
            we_q    <= b_we;
            own     <= OWN_B;
        end else if (state == DONE) begin
            own <= OWN_NONE;
        end
    end

    // Capture read data on the last oe_n-low cycle into the owner's port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else if (rd_last) begin
            if (own == OWN_A) begin
                a_rdata <= sram_dq_i;
            end else begin
                b_rdata <= sram_dq_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed timing plus random traffic.
// A transaction-level memory model predicts every read value.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    logic        a_req, b_req, a_we, b_we;
    logic [20:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata;
    logic        a_ack, b_ack;
    logic [20:0] sram_addr;
    logic [7:0]  sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]  owner;

    logic        a_req1, b_req1, a_we1, b_we1;
    logic [20:0] a_addr1, b_addr1;
    logic [7:0]  a_wdata1, b_wdata1, a_rdata1, b_rdata1;
    logic        a_ack1, b_ack1;
    logic [20:0] sram_addr1;
    logic [7:0]  sram_dq_o1, sram_dq_i1;
    logic        sram_dq_oe1, sram_ce_n1, sram_oe_n1, sram_we_n1;
    logic [1:0]  owner1;

    sram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .owner(owner)
    );

    sram_arbiter #(.RD_CYCLES(1), .WR_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req1), .a_we(a_we1), .a_addr(a_addr1), .a_wdata(a_wdata1),
        .a_rdata(a_rdata1), .a_ack(a_ack1),
        .b_req(b_req1), .b_we(b_we1), .b_addr(b_addr1), .b_wdata(b_wdata1),
        .b_rdata(b_rdata1), .b_ack(b_ack1),
        .sram_addr(sram_addr1), .sram_dq_o(sram_dq_o1),
        .sram_dq_oe(sram_dq_oe1), .sram_dq_i(sram_dq_i1),
        .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1),
        .sram_we_n(sram_we_n1), .owner(owner1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Power-up content of every SRAM location
    function automatic logic [7:0] init_val(input logic [20:0] a);
        return a[7:0] ^ a[20:13] ^ 8'h5A;
    endfunction

    // Slot of each address the bench touches in the SRAM model
    function automatic int idx(input logic [20:0] a);
        case (a)
            21'h01FFFF: return 0;
            21'h000100: return 1;
            21'h000042: return 2;
            21'h000123: return 3;
            21'h000200: return 4;
            21'h000000: return 5;
            21'h000001: return 6;
            21'h1FFFFF: return 7;
            21'h100000: return 8;
            21'h000ABC: return 9;
            default:    return 15;
        endcase
    endfunction

    // SRAM device model: writes while we_n low, drives data while oe_n low
    logic [7:0] mem [16];
    bit         wflag [16];

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            mem[idx(sram_addr)]   <= sram_dq_o;
            wflag[idx(sram_addr)] <= 1'b1;
        end
        if (!sram_ce_n && !sram_oe_n) begin
            sram_dq_i <= wflag[idx(sram_addr)] ? mem[idx(sram_addr)]
                                               : init_val(sram_addr);
        end else begin
            sram_dq_i <= 8'hA5;
        end
    end

    // Reference memory: committed writes in ack order
    logic [7:0] refmem [logic [20:0]];

    function automatic logic [7:0] exp_rd(input logic [20:0] a);
        return refmem.exists(a) ? refmem[a] : init_val(a);
    endfunction

    // Bus-rule monitors
    int   overlap_cnt = 0, dual_ack = 0, wh_bad = 0;
    int   oe_low = 0, we_low = 0, overlap1 = 0;
    logic prev_oe = 1'b0, prev_we = 1'b1, prev_rst = 1'b0;

    always @(negedge clk) begin
        if (sram_dq_oe && !sram_oe_n) overlap_cnt <= overlap_cnt + 1;
        if (sram_dq_oe1 && !sram_oe_n1) overlap1 <= overlap1 + 1;
        if (a_ack && b_ack) dual_ack <= dual_ack + 1;
        if (reset_n && prev_rst && prev_oe && !sram_dq_oe && !prev_we)
            wh_bad <= wh_bad + 1;
        if (!sram_oe_n) oe_low <= oe_low + 1;
        if (!sram_we_n) we_low <= we_low + 1;
        prev_oe  <= sram_dq_oe;
        prev_we  <= sram_we_n;
        prev_rst <= reset_n;
    end

    // One access on port p; returns edges to ack and foreign acks seen
    task automatic access(input int p, input logic we, input logic [20:0] addr,
                          input logic [7:0] wd, output int lat,
                          output int foreign);
        logic got;
        lat = 0;
        foreign = 0;
        got = 1'b0;
        if (p == 0) begin
            a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        end else begin
            b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        end
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (p == 0 ? a_ack : b_ack) got = 1'b1;
            else if (p == 0 ? b_ack : a_ack) foreign++;
        end
        if (p == 0) a_req = 1'b0;
        else b_req = 1'b0;
        check($sformatf("ack_p%0d", p), 32'(got), 32'd1);
        if (got) begin
            if (we) refmem[addr] = wd;
            else check($sformatf("rdata_p%0d_%0h", p, addr),
                       32'(p == 0 ? a_rdata : b_rdata), 32'(exp_rd(addr)));
        end
    endtask

    function automatic logic [20:0] pick_addr(input int r);
        case (r)
            0: return 21'h000000;
            1: return 21'h000001;
            2: return 21'h1FFFFF;
            3: return 21'h100000;
            4: return 21'h000ABC;
            default: return 21'h01FFFF;
        endcase
    endfunction

    int          lat, f, cnt, snap, wl;
    int          lat_a, f_a, lat_b, f_b;
    int          who;
    logic        got;
    logic [20:0] seen_addr;
    logic [7:0]  seen_dq;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        a_req1 = 0; b_req1 = 0; a_we1 = 0; b_we1 = 0;
        a_addr1 = 0; b_addr1 = 0; a_wdata1 = 0; b_wdata1 = 0;
        sram_dq_i1 = 8'hC3;

        // Reset held with both ports requesting
        a_we = 0; a_addr = 21'h01FFFF;
        b_we = 0; b_addr = 21'h000042;
        a_req = 1; b_req = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_acks", 32'({a_ack, b_ack}), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_o", 32'(sram_dq_o), 32'd0);
        check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);

        // Release: A wins first, reads 0x1FFFF (power-up value 0xAA)
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_owner", 32'(owner), 32'd1);
        check("first_oe_n", 32'(sram_oe_n), 32'd0);
        lat = 1;
        while (!a_ack && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        a_req = 0;
        check("first_lat", 32'(lat), 32'd3);
        check("first_rdata", 32'(a_rdata), 32'hAA);
        check("first_b_rdata", 32'(b_rdata), 32'd0);
        cnt = 0;
        while (!b_ack && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        b_req = 0;
        check("b_after_a", 32'(b_ack), 32'd1);
        check("b_rdata_42", 32'(b_rdata), 32'(exp_rd(21'h000042)));

        // Isolated A read: latency and oe_n pulse width
        repeat (2) @(posedge clk);
        #1;
        snap = oe_low;
        access(0, 1'b0, 21'h01FFFF, 8'h00, lat, f);
        check("rd_lat", 32'(lat), 32'd3);
        check("rd_oe_width", 32'(oe_low - snap), 32'd2);
        check("rd_b_kept", 32'(b_rdata), 32'(exp_rd(21'h000042)));

        // B write 0xEE, then a read through TURN, then back-to-back read
        repeat (2) @(posedge clk);
        #1;
        snap = we_low;
        access(1, 1'b1, 21'h000100, 8'hEE, lat, f);
        check("wr_lat", 32'(lat), 32'd5);
        check("wr_we_width", 32'(we_low - snap), 32'd2);
        check("wr_mem", 32'(mem[idx(21'h000100)]), 32'hEE);
        access(1, 1'b0, 21'h000100, 8'h00, lat, f);
        check("turn_lat", 32'(lat), 32'd5);
        access(1, 1'b0, 21'h000100, 8'h00, lat, f);
        check("b2b_lat", 32'(lat), 32'd4);

        // Both held: A reads, B writes, strict alternation from A
        a_we = 0; a_addr = 21'h000123;
        b_we = 1; b_addr = 21'h000123; b_wdata = 8'h10;
        a_req = 1; b_req = 1;
        for (int i = 0; i < 8; i++) begin
            cnt = 0;
            got = 1'b0;
            while (!got && cnt < 40) begin
                @(posedge clk); #1; cnt++;
                got = a_ack | b_ack;
            end
            who = a_ack ? 0 : (b_ack ? 1 : 2);
            check($sformatf("alt_order_%0d", i), 32'(who), 32'(i % 2));
            check($sformatf("alt_owner_%0d", i), 32'(owner),
                  (i % 2 == 0) ? 32'd1 : 32'd2);
            if (a_ack) begin
                check($sformatf("alt_rdata_%0d", i), 32'(a_rdata),
                      32'(exp_rd(21'h000123)));
            end
            if (b_ack) begin
                refmem[21'h000123] = b_wdata;
                b_wdata = b_wdata + 8'h1;
            end
        end
        a_req = 0; b_req = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset pulse during the write pulse aborts, then re-grant
        b_we = 1; b_addr = 21'h000200; b_wdata = 8'h77; b_req = 1;
        cnt = 0;
        while (sram_we_n && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        check("abort_reach_wp", 32'(sram_we_n), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_ce_n", 32'(sram_ce_n), 32'd1);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_owner", 32'(owner), 32'd0);
        @(posedge clk);
        #1;
        check("abort_no_ack", 32'(b_ack), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        lat = 0;
        while (!b_ack && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        b_req = 0;
        check("regrant_lat", 32'(lat), 32'd5);
        if (b_ack) refmem[21'h000200] = 8'h77;
        access(0, 1'b0, 21'h000200, 8'h00, lat, f);

        // Random concurrent traffic on both ports
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    access(0, 1'($urandom_range(0, 1)),
                           pick_addr(int'($urandom_range(0, 5))),
                           8'($urandom), lat_a, f_a);
                    check("fair_a", 32'(f_a <= 1), 32'd1);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    access(1, 1'($urandom_range(0, 1)),
                           pick_addr(int'($urandom_range(0, 5))),
                           8'($urandom), lat_b, f_b);
                    check("fair_b", 32'(f_b <= 1), 32'd1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Minimum pulse widths on the second instance, top address
        a_addr1 = 21'h1FFFFF; a_we1 = 0; a_req1 = 1;
        lat = 0; got = 1'b0; seen_addr = '0;
        while (!got && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) seen_addr = sram_addr1;
            got = a_ack1;
        end
        a_req1 = 0;
        check("e_rd_lat", 32'(lat), 32'd2);
        check("e_rd_data", 32'(a_rdata1), 32'hC3);
        check("e_rd_addr", 32'(seen_addr), 32'h1FFFFF);
        repeat (2) @(posedge clk);
        #1;
        b_addr1 = 21'h1FFFFF; b_we1 = 1; b_wdata1 = 8'h5A; b_req1 = 1;
        lat = 0; got = 1'b0; wl = 0; seen_dq = '0; seen_addr = '0;
        while (!got && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (!sram_we_n1) begin
                wl++;
                seen_dq = sram_dq_o1;
                seen_addr = sram_addr1;
            end
            got = b_ack1;
        end
        b_req1 = 0;
        check("e_wr_lat", 32'(lat), 32'd4);
        check("e_wr_width", 32'(wl), 32'd1);
        check("e_wr_dq", 32'(seen_dq), 32'h5A);
        check("e_wr_addr", 32'(seen_addr), 32'h1FFFFF);
        repeat (2) @(posedge clk);
        #1;

        check("oe_dq_overlap", 32'(overlap_cnt), 32'd0);
        check("oe_dq_overlap1", 32'(overlap1), 32'd0);
        check("dual_ack", 32'(dual_ack), 32'd0);
        check("wh_before_release", 32'(wh_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
